// File: rtl/spi_pkg.sv
// Shared SPI mode-0 definitions for the master transmitter and the slave receiver.
// Holds the FSM state encoding, clock polarity/phase constants and a counter-width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    GUARD = 2'd3
  } spi_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period timer: counts 0..CLK_DIV-1 and strobes phase_end on the final count.
// Zero latency strobe from the counter register; restart holds the count at zero.
module spi_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_end,
  output logic next_end
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (restart || (cnt == LAST)) begin
      cnt_nxt = '0;
    end
  end

  assign phase_end = (cnt == LAST);
  // Lets the FSM register outputs that must be high exactly in the final cycle of a phase.
  assign next_end  = (cnt_nxt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter, MSB first; first rising sclk CLK_DIV+1 cycles after accept.
// tx_ready only in IDLE or the last sclk-high cycle of a word, so held tx_valid streams with ss low.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = cnt_width(DATA_W);

  spi_state_t        state, state_nxt;
  logic [DATA_W-1:0] shift_q, shift_nxt, shift_shl;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic              sclk_nxt, mosi_nxt, ss_nxt, busy_nxt;
  logic              ready_nxt, done_nxt;
  logic              accept;
  logic              phase_end, next_end;

  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart   (state == IDLE),
    .phase_end (phase_end),
    .next_end  (next_end)
  );

  assign accept    = tx_valid && tx_ready;
  assign shift_shl = shift_q << 1;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    bit_nxt   = bit_cnt;
    sclk_nxt  = sclk;
    mosi_nxt  = mosi;
    ss_nxt    = ss;
    busy_nxt  = busy;

    case (state)
      IDLE: begin
        sclk_nxt = SPI_CPOL;
        ss_nxt   = 1'b1;
        if (accept) begin
          state_nxt = LOW;
          shift_nxt = tx_data;
          bit_nxt   = BIT_W'(DATA_W - 1);
          mosi_nxt  = tx_data[DATA_W-1];
          ss_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_nxt = HIGH;
          sclk_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_nxt = 1'b0;
          if (bit_cnt != '0) begin
            state_nxt = LOW;
            bit_nxt   = bit_cnt - BIT_W'(1);
            shift_nxt = shift_shl;
            mosi_nxt  = shift_shl[DATA_W-1];
          end else if (accept) begin
            // Next word starts straight away so the receiver's framing never sees ss rise.
            state_nxt = LOW;
            shift_nxt = tx_data;
            bit_nxt   = BIT_W'(DATA_W - 1);
            mosi_nxt  = tx_data[DATA_W-1];
          end else begin
            state_nxt = GUARD;
          end
        end
      end
      GUARD: begin
        if (phase_end) begin
          state_nxt = IDLE;
          ss_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          mosi_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    done_nxt  = (state_nxt == HIGH) && next_end && (bit_nxt == '0);
    ready_nxt = (state_nxt == IDLE) || done_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      sclk     <= SPI_CPOL;
      mosi     <= 1'b0;
      ss       <= 1'b1;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      bit_cnt  <= bit_nxt;
      sclk     <= sclk_nxt;
      mosi     <= mosi_nxt;
      ss       <= ss_nxt;
      busy     <= busy_nxt;
      tx_ready <= ready_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: CLK_DIV=4 and CLK_DIV=1 instances with a mode-0 loopback slave model.
module tb_spi_master_tx;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][7:0] tx_data_v;
  logic [1:0]      tx_valid_v;
  logic [1:0]      ready_v, sclk_v, mosi_v, ss_v, busy_v, done_v;

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  spi_master_tx #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(ready_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .ss(ss_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  spi_master_tx #(.DATA_W(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
    .tx_ready(ready_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .ss(ss_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  // Loopback slave receiver and line monitor, one per instance.
  int         rise[2], sslow[2], ssrise[2], donec[2], bad_edge[2], glitch[2], nontog[2];
  int         bits[2], rxn[2];
  logic [7:0] rxsh[2];
  logic [7:0] rxlog[2][64];
  logic [1:0] sclk_p = 2'b00;
  logic [1:0] ss_p   = 2'b11;
  logic [1:0] mosi_p = 2'b00;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rise[i] = 0; sslow[i] = 0; ssrise[i] = 0; donec[i] = 0; bad_edge[i] = 0;
      glitch[i] = 0; nontog[i] = 0; bits[i] = 0; rxn[i] = 0; rxsh[i] = 8'h00;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk_v[i] === 1'b1 && sclk_p[i] === 1'b0) begin
        rise[i]++;
        if (ss_v[i] !== 1'b0) begin
          bad_edge[i]++;
        end else begin
          rxsh[i] = {rxsh[i][6:0], mosi_v[i]};
          bits[i]++;
          if (bits[i] == 8) begin
            if (rxn[i] < 64) rxlog[i][rxn[i]] = rxsh[i];
            rxn[i]++;
            bits[i] = 0;
          end
        end
      end
      if (ss_v[i] === 1'b1) bits[i] = 0;
      if (sclk_v[i] === 1'b1 && mosi_v[i] !== mosi_p[i]) glitch[i]++;
      if (ss_v[i] === 1'b0) sslow[i]++;
      if (ss_v[i] === 1'b1 && ss_p[i] === 1'b0) ssrise[i]++;
      if (done_v[i] === 1'b1) donec[i]++;
      if (ss_v[i] === 1'b0 && ss_p[i] === 1'b0 && sclk_v[i] === sclk_p[i]) nontog[i]++;
      sclk_p[i] = sclk_v[i];
      ss_p[i]   = ss_v[i];
      mosi_p[i] = mosi_v[i];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int last_rx(input int i, input int k);
    if (rxn[i] < k || rxn[i] - k >= 64) return -1;
    return int'(rxlog[i][rxn[i]-k]);
  endfunction

  // Presents one word, returns ticks from the first post-accept cycle to sclk high and that cycle's mosi.
  task automatic send_word(input int i, input logic [7:0] d, output int lat, output int m0);
    int n;
    n = 0;
    tx_data_v[i] = d;
    tx_valid_v[i] = 1'b1;
    while (ready_v[i] !== 1'b1 && n < 50) begin tick(); n++; end
    chk("accept_timeout", int'(n < 50), 1);
    tick();
    tx_valid_v[i] = 1'b0;
    m0 = int'(mosi_v[i]);
    chk("accept_ss", int'(ss_v[i]), 0);
    chk("accept_busy", int'(busy_v[i]), 1);
    chk("accept_ready", int'(ready_v[i]), 0);
    lat = 0;
    while (sclk_v[i] !== 1'b1 && lat < 50) begin tick(); lat++; end
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy_v[i] !== 1'b0 && n < 1000) begin tick(); n++; end
    chk("idle_timeout", int'(n < 1000), 1);
  endtask

  // Holds tx_valid across two words; reports line state in the cycle the second word is accepted.
  task automatic b2b(input int i, input logic [7:0] d0, input logic [7:0] d1,
                     output int r_rise, output int r_sclk, output int r_done);
    int n;
    int base;
    base = rise[i];
    n = 0;
    tx_data_v[i] = d0;
    tx_valid_v[i] = 1'b1;
    while (ready_v[i] !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    tx_data_v[i] = d1;
    n = 0;
    while (ready_v[i] !== 1'b1 && n < 500) begin tick(); n++; end
    chk("b2b_accept_timeout", int'(n < 500), 1);
    r_rise = rise[i] - base;
    r_sclk = int'(sclk_v[i]);
    r_done = int'(done_v[i]);
    tick();
    tx_valid_v[i] = 1'b0;
    tx_data_v[i] = 8'h00;
  endtask

  typedef struct {
    logic [7:0] data;
    int         msb;
    int         rises;
    int         sslow;
    int         dones;
    logic [7:0] rx;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, m0, r_rise, r_sclk, r_done;
    int s_rise, s_sslow, s_ssrise, s_done, s_rxn;

    tbl[0] = '{8'hA5, 1, 8, 68, 1, 8'hA5};
    tbl[1] = '{8'h00, 0, 8, 68, 1, 8'h00};
    tbl[2] = '{8'hFF, 1, 8, 68, 1, 8'hFF};
    tbl[3] = '{8'h81, 1, 8, 68, 1, 8'h81};
    tbl[4] = '{8'h5A, 0, 8, 68, 1, 8'h5A};

    rst = 1'b1;
    tx_valid_v = 2'b00;
    tx_data_v = '0;
    repeat (3) tick();
    chk("rst_ss", int'(ss_v[0]), 1);
    chk("rst_sclk", int'(sclk_v[0]), 0);
    chk("rst_mosi", int'(mosi_v[0]), 0);
    chk("rst_ready", int'(ready_v[0]), 0);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_done", int'(done_v[0]), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", int'(ready_v[0]), 1);
    chk("post_rst_ready1", int'(ready_v[1]), 1);

    for (int v = 0; v < 5; v++) begin
      s_rise = rise[0]; s_sslow = sslow[0]; s_ssrise = ssrise[0]; s_done = donec[0];
      send_word(0, tbl[v].data, lat, m0);
      chk("first_rise_latency", lat, 4);
      chk("first_mosi", m0, tbl[v].msb);
      wait_idle(0);
      chk("word_rises", rise[0] - s_rise, tbl[v].rises);
      chk("word_ss_low", sslow[0] - s_sslow, tbl[v].sslow);
      chk("word_done", donec[0] - s_done, tbl[v].dones);
      chk("word_ss_rise", ssrise[0] - s_ssrise, 1);
      chk("word_rx", last_rx(0, 1), int'(tbl[v].rx));
      chk("idle_mosi", int'(mosi_v[0]), 0);
      chk("idle_ready", int'(ready_v[0]), 1);
    end

    // Back-to-back words keep ss low across the boundary.
    s_rise = rise[0]; s_sslow = sslow[0]; s_ssrise = ssrise[0]; s_done = donec[0];
    b2b(0, 8'h3C, 8'hC3, r_rise, r_sclk, r_done);
    chk("b2b_accept_rise", r_rise, 8);
    chk("b2b_accept_sclk", r_sclk, 1);
    chk("b2b_accept_done", r_done, 1);
    wait_idle(0);
    chk("b2b_rises", rise[0] - s_rise, 16);
    chk("b2b_ss_low", sslow[0] - s_sslow, 132);
    chk("b2b_ss_rise", ssrise[0] - s_ssrise, 1);
    chk("b2b_done", donec[0] - s_done, 2);
    chk("b2b_rx0", last_rx(0, 2), 8'h3C);
    chk("b2b_rx1", last_rx(0, 1), 8'hC3);

    // tx_valid raised mid-word is held off until the last high cycle; later tx_data changes ignored.
    s_rise = rise[0];
    send_word(0, 8'h96, lat, m0);
    lat = 0;
    while (rise[0] - s_rise < 4 && lat < 100) begin tick(); lat++; end
    tx_data_v[0] = 8'h42;
    tx_valid_v[0] = 1'b1;
    lat = 0;
    while (ready_v[0] !== 1'b1 && lat < 200) begin tick(); lat++; end
    chk("held_accept_rise", rise[0] - s_rise, 8);
    chk("held_accept_sclk", int'(sclk_v[0]), 1);
    chk("held_accept_done", int'(done_v[0]), 1);
    tick();
    tx_valid_v[0] = 1'b0;
    tx_data_v[0] = 8'hFF;
    wait_idle(0);
    chk("held_rx0", last_rx(0, 2), 8'h96);
    chk("held_rx1", last_rx(0, 1), 8'h42);

    // Reset after the third rising edge aborts the word.
    s_rise = rise[0]; s_done = donec[0]; s_rxn = rxn[0];
    send_word(0, 8'h81, lat, m0);
    lat = 0;
    while (rise[0] - s_rise < 3 && lat < 100) begin tick(); lat++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ss", int'(ss_v[0]), 1);
    chk("abort_sclk", int'(sclk_v[0]), 0);
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_ready", int'(ready_v[0]), 0);
    tick();
    chk("abort_ready_after", int'(ready_v[0]), 1);
    repeat (40) tick();
    chk("abort_rises", rise[0] - s_rise, 3);
    chk("abort_done", donec[0] - s_done, 0);
    chk("abort_rx", rxn[0] - s_rxn, 0);

    // CLK_DIV=1 stress: sclk toggles every cycle while ss is low.
    s_rise = rise[1]; s_sslow = sslow[1]; s_ssrise = ssrise[1]; s_done = donec[1];
    b2b(1, 8'hFF, 8'h00, r_rise, r_sclk, r_done);
    chk("fast_accept_rise", r_rise, 8);
    chk("fast_accept_sclk", r_sclk, 1);
    wait_idle(1);
    chk("fast_rises", rise[1] - s_rise, 16);
    chk("fast_ss_low", sslow[1] - s_sslow, 33);
    chk("fast_ss_rise", ssrise[1] - s_ssrise, 1);
    chk("fast_done", donec[1] - s_done, 2);
    chk("fast_rx0", last_rx(1, 2), 8'hFF);
    chk("fast_rx1", last_rx(1, 1), 8'h00);
    chk("fast_nontoggle", nontog[1], 0);

    s_rise = rise[1];
    send_word(1, 8'hA5, lat, m0);
    chk("fast_first_latency", lat, 1);
    wait_idle(1);
    chk("fast_single_rx", last_rx(1, 1), 8'hA5);

    chk("bad_edges0", bad_edge[0], 0);
    chk("bad_edges1", bad_edge[1], 0);
    chk("mosi_glitch0", glitch[0], 0);
    chk("mosi_glitch1", glitch[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
